// File: rtl/issue_queue_if.sv
// Decode/issue-side signal bundle for issue_queue.
// The master modport is the decode+issue side and the slave modport is the queue.
interface issue_queue_if #(
  parameter int unsigned Depth = 8,
  parameter int unsigned Width = 32
) ();
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [1:0]            push_num;
  logic [1:0][Width-1:0] push_data;
  logic                  push_allow;
  logic [CntW-1:0]       iq_count;
  logic [1:0]            iq_size;
  logic [1:0][Width-1:0] issue_require;
  logic [1:0]            iq_pop_number;

  modport master (
    output push_num, push_data, iq_pop_number,
    input  push_allow, iq_count, iq_size, issue_require
  );

  modport slave (
    input  push_num, push_data, iq_pop_number,
    output push_allow, iq_count, iq_size, issue_require
  );
endinterface

// File: rtl/issue_queue.sv
// Circular issue queue: decode pushes 0..2 entries per cycle and issue pops 0..2 entries per cycle.
// The two oldest entries are presented from registered state only, so there is no bypass.
module issue_queue #(
  parameter int unsigned Depth = 8,
  parameter int unsigned Width = 32
) (
  input logic          clk,
  input logic          rst,
  input logic          flash,
  issue_queue_if.slave iq
);
  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  head_q, head_d, tail_q, tail_d, head_p1, tail_p1;
  logic [CntW-1:0]  count_q, count_d;
  logic [1:0]       size;
  logic [1:0]       acc_push, eff_pop;
  logic             allow;

  assign head_p1 = head_q + PtrW'(1);
  assign tail_p1 = tail_q + PtrW'(1);

  always_comb begin
    allow = (count_q <= CntW'(Depth - 2));
    size  = (count_q >= CntW'(2)) ? 2'd2 : count_q[1:0];
  end

  always_comb begin
    iq.push_allow       = allow;
    iq.iq_count         = count_q;
    iq.iq_size          = size;
    iq.issue_require[0] = (size != 2'd0) ? mem_q[head_q]  : '0;
    iq.issue_require[1] = (size == 2'd2) ? mem_q[head_p1] : '0;
  end

  // push_num=3 is illegal and is dropped rather than half-applied.
  always_comb begin
    acc_push = '0;
    if (allow && (iq.push_num != 2'd3)) acc_push = iq.push_num;
    eff_pop = (iq.iq_pop_number > size) ? size : iq.iq_pop_number;
    head_d  = head_q + PtrW'(eff_pop);
    tail_d  = tail_q + PtrW'(acc_push);
    count_d = count_q + CntW'(acc_push) - CntW'(eff_pop);
  end

  always_ff @(posedge clk) begin
    if (rst || flash) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage is never cleared; a flushed entry is simply unreachable.
  always_ff @(posedge clk) begin
    if (!rst && !flash) begin
      if (acc_push != 2'd0) mem_q[tail_q]  <= iq.push_data[0];
      if (acc_push == 2'd2) mem_q[tail_p1] <= iq.push_data[1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !flash) begin
      assert (iq.iq_pop_number <= size)
        else $warning("issue_queue: pop of %0d exceeds size %0d, clamped", iq.iq_pop_number, size);
      assert (iq.push_num != 2'd3)
        else $warning("issue_queue: illegal push_num=3 ignored");
    end
  end
endmodule

// File: tb/tb_issue_queue.sv
// Directed bench for issue_queue with a queue-based scoreboard of expected entries.
module tb_issue_queue;
  localparam int unsigned Depth = 8;
  localparam int unsigned Width = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic flash = 1'b0;
  int   tests = 0;
  int   fails = 0;
  logic [Width-1:0] sb[$];
  logic [Width-1:0] nxt = 16'h0100;

  always #5 clk = ~clk;

  issue_queue_if #(.Depth(Depth), .Width(Width)) iq ();

  issue_queue #(.Depth(Depth), .Width(Width)) dut (
    .clk   (clk),
    .rst   (rst),
    .flash (flash),
    .iq    (iq.slave)
  );

  task automatic expect_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
      else begin
        fails++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  // Compares every output against the scoreboard contents.
  task automatic chk(input string tag);
    int n;
    logic [Width-1:0] e0, e1;
    n  = sb.size();
    e0 = (n > 0) ? sb[0] : '0;
    e1 = (n > 1) ? sb[1] : '0;
    expect_eq({tag, ".count"}, 32'(iq.iq_count), 32'(n));
    expect_eq({tag, ".size"}, 32'(iq.iq_size), 32'((n > 2) ? 2 : n));
    expect_eq({tag, ".allow"}, 32'(iq.push_allow), 32'(((Depth - n) >= 2) ? 1 : 0));
    expect_eq({tag, ".req0"}, 32'(iq.issue_require[0]), 32'(e0));
    expect_eq({tag, ".req1"}, 32'(iq.issue_require[1]), 32'(e1));
  endtask

  task automatic cycle(input int pn, input int pop, input bit fl = 1'b0, input bit rs = 1'b0);
    int n, sz, ep;
    logic [Width-1:0] d0, d1;
    d0 = nxt;
    d1 = nxt + 16'd1;
    iq.push_num         = 2'(pn);
    iq.push_data[0]     = d0;
    iq.push_data[1]     = d1;
    iq.iq_pop_number    = 2'(pop);
    flash               = fl;
    rst                 = rs;
    n  = sb.size();
    sz = (n > 2) ? 2 : n;
    @(posedge clk);
    #1;
    if (rs || fl) begin
      sb.delete();
    end else begin
      ep = (pop > sz) ? sz : pop;
      repeat (ep) void'(sb.pop_front());
      if ((Depth - n) >= 2) begin
        if (pn >= 1) sb.push_back(d0);
        if (pn == 2) sb.push_back(d1);
      end
    end
    nxt = nxt + 16'd2;
    iq.push_num      = '0;
    iq.iq_pop_number = '0;
    flash            = 1'b0;
    rst              = 1'b0;
  endtask

  initial begin
    iq.push_num      = '0;
    iq.push_data     = '0;
    iq.iq_pop_number = '0;
    @(negedge clk);

    // 1 reset
    cycle(0, 0, 1'b0, 1'b1);
    cycle(0, 0, 1'b0, 1'b1);
    cycle(0, 0);
    chk("reset");
    expect_eq("reset.count_const", 32'(iq.iq_count), 32'd0);
    expect_eq("reset.allow_const", 32'(iq.push_allow), 32'd1);

    // 2 push into empty: not visible during the push cycle
    iq.push_num = 2'd2;
    #1;
    expect_eq("empty_push.size_same_cycle", 32'(iq.iq_size), 32'd0);
    cycle(2, 0);
    chk("empty_push");
    expect_eq("empty_push.A", 32'(iq.issue_require[0]), 32'(nxt - 16'd2));
    expect_eq("empty_push.B", 32'(iq.issue_require[1]), 32'(nxt - 16'd1));

    // 3 fill to Depth, then an ignored push, then drain in order
    cycle(0, 0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      cycle(2, 0);
      chk("fill");
    end
    expect_eq("fill.count8", 32'(iq.iq_count), 32'd8);
    expect_eq("fill.allow0", 32'(iq.push_allow), 32'd0);
    cycle(2, 0);
    chk("fill.ignored");
    expect_eq("fill.still8", 32'(iq.iq_count), 32'd8);
    for (int i = 0; i < 4; i++) begin
      cycle(0, 2);
      chk("drain");
    end

    // count 7 boundary
    cycle(0, 0, 1'b1);
    for (int i = 0; i < 3; i++) cycle(2, 0);
    cycle(1, 0);
    chk("count7");
    expect_eq("count7.allow0", 32'(iq.push_allow), 32'd0);

    // 4 wrap: reach head=6 holding 2, then stream 2 in / 2 out
    cycle(0, 0, 1'b1);
    cycle(2, 0);
    for (int i = 0; i < 3; i++) cycle(2, 2);
    for (int i = 0; i < 8; i++) begin
      cycle(2, 2);
      chk("wrap");
    end
    expect_eq("wrap.count2", 32'(iq.iq_count), 32'd2);

    // 5 pop clamp and partial pop
    cycle(0, 0, 1'b1);
    cycle(1, 0);
    cycle(0, 2);
    chk("clamp");
    expect_eq("clamp.count0", 32'(iq.iq_count), 32'd0);
    cycle(2, 0);
    cycle(1, 0);
    cycle(0, 1);
    chk("partial_pop");
    expect_eq("partial_pop.size2", 32'(iq.iq_size), 32'd2);

    // 6 flush wins over same-cycle push/pop; reset with flush
    cycle(0, 0, 1'b1);
    cycle(2, 0);
    cycle(2, 0);
    cycle(1, 0);
    expect_eq("flush.pre_count5", 32'(iq.iq_count), 32'd5);
    cycle(2, 1, 1'b1);
    chk("flush");
    cycle(2, 0);
    cycle(2, 1, 1'b1, 1'b1);
    chk("flush_rst");

    // mixed traffic
    for (int i = 0; i < 24; i++) begin
      cycle(int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
      chk("mixed");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
